decode_scoreboard: RTL
======================

# decode_scoreboard

Register-hazard scoreboard for the decode stage. It tracks in-flight writes to the 32 scalar and 32 vector registers and stalls the instruction in decode on RAW or WAW hazards until the producing writeback completes. It also provides a drain sequence (stall until no writes are outstanding) for fences, halts and CSR-style instructions. It sits beside the decode stage: it reads the decoded source/destination fields and the writeback strobes from the scalar and vector register-file write ports.

## Interface
- NREGS, 32, registers per file (scalar and vector each)
- ADDR_W, 5, register address width; must equal clog2(NREGS)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode holds a valid instruction
- s_src1_en, s_src2_en  in  1 each  scalar source read used
- s_src1, s_src2  in  ADDR_W each  scalar source addresses
- v_src1_en, v_src2_en  in  1 each  vector source read used
- v_src1, v_src2  in  ADDR_W each  vector source addresses
- s_dst_en, v_dst_en  in  1 each  instruction writes scalar / vector register
- s_dst, v_dst  in  ADDR_W each  destination addresses
- s_wb_en, v_wb_en  in  1 each  writeback to scalar / vector file this cycle
- s_wb_addr, v_wb_addr  in  ADDR_W each  writeback addresses
- drain_req  in  1  one-cycle request to drain all outstanding writes
- stall  out  1  hold decode; instruction not issued this cycle
- issue_fire  out  1  issue_valid & ~stall; destination bits set at this edge
- drain_done  out  1  one-cycle pulse: drain complete
- inflight  out  ADDR_W+2  count of set busy bits (0..2*NREGS)
- s_busy, v_busy  out  NREGS each  busy vectors
- wb_err  out  1  sticky: writeback to a non-busy register seen

## Operation
- State: s_busy, v_busy, inflight, FSM {IDLE, DRAIN}, wb_err. Register 0 is not special-cased.
- hazard = any enabled source or enabled destination whose busy bit is 1. Scalar fields check s_busy; vector fields check v_busy.
- stall = issue_valid & (hazard | drain_req | state==DRAIN). stall is 0 whenever issue_valid is 0.
- On issue_fire: set s_busy[s_dst] if s_dst_en; set v_busy[v_dst] if v_dst_en.
- On s_wb_en: clear s_busy[s_wb_addr] if it is set. Otherwise leave it unchanged and set wb_err. The same rule applies to v_wb_en with v_busy.
- A writeback does not bypass a hazard in the same cycle. The cleared bit is first visible the next cycle.
- Set and clear of the same bit in one cycle cannot occur legally: a set requires the bit clear, and the WAW check blocks a set on a busy register. If it does occur, the clear is treated as spurious (wb_err=1) and the set wins.
- inflight next = inflight + (number of sets) − (number of valid clears). Valid clears are those that hit a busy bit. The per-cycle delta lies in −2..+2. inflight always equals popcount(s_busy)+popcount(v_busy).
- FSM:
  - IDLE: on drain_req, go to DRAIN.
  - DRAIN: if inflight==0, assert drain_done and go to IDLE; otherwise stay in DRAIN.
  - drain_req while in DRAIN is ignored.
  - Writebacks continue normally during DRAIN.

## Timing
- Reset (asynchronous, rst_n low):
  - busy vectors = 0, inflight = 0, state = IDLE, wb_err = 0.
  - stall = 0 while issue_valid = 0; drain_done = 0; issue_fire = 0.
- stall, issue_fire and drain_done are combinational from registered state and current-cycle inputs. They have no internal register.
- Busy update latency is 1 cycle. A destination issued in cycle N reads busy from cycle N+1.
- A writeback in cycle N unstalls a dependent instruction in cycle N+1.
- Drain timing: drain_req in cycle N with an empty scoreboard gives drain_done in cycle N+1 and IDLE in N+2. Issue is blocked in both N and N+1.
- Reset asserted mid-DRAIN returns to IDLE with no drain_done pulse. All pending busy bits are discarded.

## Test plan
- Sequence: issue with s_dst_en=1, s_dst=5 (cycle 0). Next cycle, issue_valid with s_src1_en=1, s_src1=5. Required: stall=1. Then s_wb_en=1, s_wb_addr=5 in cycle 3. Required: stall=1 in cycle 3, stall=0 and issue_fire=1 in cycle 4, s_busy[5]=0.
- WAW: v_dst=7 busy; new issue with v_dst_en=1, v_dst=7. Required: stall=1 until a v_wb to 7, then fire. Scalar r7 busy alone does not stall a vector source v7.
- Dual writeback: s_busy[3]=1 and v_busy[3]=1 with inflight=2. Drive s_wb and v_wb to address 3 in the same cycle. Required: inflight=0 next cycle and both bits clear.
- Drain: inflight=2, drain_req pulse in cycle 0. Required: stall=1 throughout; writebacks in cycles 2 and 4; drain_done exactly in cycle 5; IDLE in cycle 6. On an empty scoreboard: drain_done in cycle 1.
- Spurious writeback: s_wb_en=1, s_wb_addr=9 with s_busy[9]=0. Required: wb_err=1 and sticky until reset; inflight unchanged.
- Reset: assert rst_n=0 mid-DRAIN with inflight=3. Required: busy=0, inflight=0, IDLE, wb_err=0, no drain_done pulse.

Source files
------------

// File: rtl/decode_scoreboard.sv
// decode_scoreboard
//   Register-hazard scoreboard beside the decode stage. Tracks outstanding
//   writes to the scalar and vector register files and stalls decode on
//   RAW/WAW hazards. A drain request stalls issue until no writes remain.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   issue_valid                    decode holds a valid instruction
//   s_src1/2(_en), v_src1/2(_en)   source fields (scalar / vector)
//   s_dst(_en), v_dst(_en)         destination fields
//   s_wb_en/addr, v_wb_en/addr     register-file writeback strobes
//   drain_req                      one-cycle drain request
//   stall, issue_fire              decode hold / instruction accepted
//   drain_done                     one-cycle drain-complete pulse
//   inflight                       number of busy bits set
//   s_busy, v_busy                 busy vectors
//   wb_err                         sticky: writeback to a non-busy register
//
// FSM states
//   state | meaning
//   IDLE  | normal issue
//   DRAIN | issue blocked until inflight reaches zero
module decode_scoreboard #(
   parameter int NREGS  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic              s_src1_en,
   input  logic              s_src2_en,
   input  logic [ADDR_W-1:0] s_src1,
   input  logic [ADDR_W-1:0] s_src2,
   input  logic              v_src1_en,
   input  logic              v_src2_en,
   input  logic [ADDR_W-1:0] v_src1,
   input  logic [ADDR_W-1:0] v_src2,
   input  logic              s_dst_en,
   input  logic              v_dst_en,
   input  logic [ADDR_W-1:0] s_dst,
   input  logic [ADDR_W-1:0] v_dst,
   input  logic              s_wb_en,
   input  logic              v_wb_en,
   input  logic [ADDR_W-1:0] s_wb_addr,
   input  logic [ADDR_W-1:0] v_wb_addr,
   input  logic              drain_req,
   output logic              stall,
   output logic              issue_fire,
   output logic              drain_done,
   output logic [ADDR_W+1:0] inflight,
   output logic [NREGS-1:0]  s_busy,
   output logic [NREGS-1:0]  v_busy,
   output logic              wb_err
);

   localparam int INF_W = ADDR_W + 2;

   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

   state_t            state, state_nxt;
   logic              hazard;
   logic              s_set, v_set, s_clr, v_clr, s_spur, v_spur;
   logic [NREGS-1:0]  s_busy_nxt, v_busy_nxt;
   logic [INF_W-1:0]  inflight_nxt;

   always_comb begin
      hazard = (s_src1_en & s_busy[s_src1]) |
               (s_src2_en & s_busy[s_src2]) |
               (s_dst_en  & s_busy[s_dst])  |
               (v_src1_en & v_busy[v_src1]) |
               (v_src2_en & v_busy[v_src2]) |
               (v_dst_en  & v_busy[v_dst]);
   end

   assign stall      = issue_valid & (hazard | drain_req | (state == DRAIN));
   assign issue_fire = issue_valid & ~stall;

   // A set only fires on a clear bit (WAW check), so a same-bit set/clear
   // always sees the clear as spurious and the set wins naturally.
   assign s_set  = issue_fire & s_dst_en;
   assign v_set  = issue_fire & v_dst_en;
   assign s_clr  = s_wb_en &  s_busy[s_wb_addr];
   assign v_clr  = v_wb_en &  v_busy[v_wb_addr];
   assign s_spur = s_wb_en & ~s_busy[s_wb_addr];
   assign v_spur = v_wb_en & ~v_busy[v_wb_addr];

   always_comb begin
      s_busy_nxt = s_busy;
      v_busy_nxt = v_busy;
      if (s_clr) s_busy_nxt[s_wb_addr] = 1'b0;
      if (v_clr) v_busy_nxt[v_wb_addr] = 1'b0;
      if (s_set) s_busy_nxt[s_dst]     = 1'b1;
      if (v_set) v_busy_nxt[v_dst]     = 1'b1;
      inflight_nxt = inflight + INF_W'(s_set) + INF_W'(v_set)
                              - INF_W'(s_clr) - INF_W'(v_clr);
   end

   always_comb begin
      state_nxt  = state;
      drain_done = 1'b0;
      case (state)
         IDLE: begin
            if (drain_req) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (inflight == '0) begin
               drain_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         s_busy   <= '0;
         v_busy   <= '0;
         inflight <= '0;
         wb_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         s_busy   <= s_busy_nxt;
         v_busy   <= v_busy_nxt;
         inflight <= inflight_nxt;
         if (s_spur | v_spur) wb_err <= 1'b1;
      end
   end

endmodule
